load_store_unit: RTL and testbench

- Sequential data-memory access unit between the multicycle datapath (address from ALU result, store data from register B) and the 64-bit data memory.
- Executes RV64I loads LB/LH/LW/LD/LBU/LHU/LWU and stores SB/SH/SW/SD against a doubleword-wide, little-endian memory.
- Loads: extraction plus sign or zero extension. Sub-doubleword stores: read-modify-write. The control FSM gets a start/done handshake and waits on done instead of hard-coding memory cycles.

---
 rtl/load_store_unit_pkg.sv | 51 +++++
 rtl/load_store_unit_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: FSM encoding, funct3 codes,
// access-size encoding and request decode helpers.
package load_store_unit_pkg;

   localparam int MEM_RD_LAT_MIN = 1;
   localparam int MEM_RD_LAT_MAX = 4;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_READ   = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef struct packed {
      logic       is_store;
      size_e      size;
      logic       is_signed;
      logic [2:0] offset;
   } req_t;

   // Stores have no unsigned variants, so any funct3 with bit 2 set is illegal.
   function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
      return is_store ? f3[2] : (f3 == 3'b111);
   endfunction

   function automatic logic misaligned(input size_e sz, input logic [2:0] off);
      logic bad;
      case (sz)
         SZ_H:    bad = off[0];
         SZ_W:    bad = |off[1:0];
         SZ_D:    bad = |off;
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: extract-and-extend for loads, byte-merge into the read
// doubleword for sub-doubleword stores.
module lsu_lane_align
   import load_store_unit_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [2:0]        offset_i,
   input  size_e             size_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] rdata_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] load_o,
   output logic [DATA_W-1:0] merge_o
);

   logic [5:0]        shamt;
   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] lane_mask;
   logic [DATA_W-1:0] mask_sh;
   logic              sign_b;
   logic              sign_h;
   logic              sign_w;

   assign shamt   = {offset_i, 3'b000};
   assign shifted = rdata_i >> shamt;
   assign sign_b  = signed_i & shifted[7];
   assign sign_h  = signed_i & shifted[15];
   assign sign_w  = signed_i & shifted[31];

   always_comb begin
      load_o    = shifted;
      lane_mask = '1;
      case (size_i)
         SZ_B: begin
            load_o    = {{56{sign_b}}, shifted[7:0]};
            lane_mask = 64'h0000_0000_0000_00FF;
         end
         SZ_H: begin
            load_o    = {{48{sign_h}}, shifted[15:0]};
            lane_mask = 64'h0000_0000_0000_FFFF;
         end
         SZ_W: begin
            load_o    = {{32{sign_w}}, shifted[31:0]};
            lane_mask = 64'h0000_0000_FFFF_FFFF;
         end
         default: begin
            load_o    = rdata_i;
            lane_mask = '1;
         end
      endcase
   end

   assign mask_sh = lane_mask << shamt;
   assign merge_o = (rdata_i & ~mask_sh) | ((wdata_i & lane_mask) << shamt);

endmodule

// File: rtl/load_store_unit.sv
// Multicycle RV64I load/store unit against a doubleword-wide little-endian memory;
// sub-doubleword stores are done as read-modify-write.
//
//  state     | meaning
//  ----------+---------------------------------------------------------------
//  ST_IDLE   | waiting for start; request latched and decoded on acceptance
//  ST_READ   | mem_addr held for MEM_RD_LAT cycles, rdata captured on the last
//  ST_WRITE  | mem_wr pulsed with merged (or full SD) doubleword
//  ST_FINISH | done pulse, err valid; back to idle next cycle
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int MEM_RD_LAT = 1,
   parameter int DATA_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata
);

   // Out-of-range latencies are clamped so the counter never wraps.
   localparam int CNT_INIT_I = (MEM_RD_LAT < MEM_RD_LAT_MIN) ? 0 :
                               (MEM_RD_LAT > MEM_RD_LAT_MAX) ? MEM_RD_LAT_MAX - 1 :
                               MEM_RD_LAT - 1;
   localparam logic [1:0] CNT_INIT = 2'(CNT_INIT_I);

   logic [1:0]        state_q, state_d;
   logic [1:0]        cnt_q, cnt_d;
   req_t              req_q, req_d;
   logic [DATA_W-1:0] sdata_q, sdata_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic [DATA_W-1:0] maddr_q, maddr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              wr_q, wr_d;

   size_e             size_in;
   logic              bad_in;
   logic [DATA_W-1:0] load_ext;
   logic [DATA_W-1:0] merged;

   assign size_in = size_e'(funct3[1:0]);
   assign bad_in  = f3_illegal(is_store, funct3) | misaligned(size_in, addr[2:0]);

   lsu_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .offset_i (req_q.offset),
      .size_i   (req_q.size),
      .signed_i (req_q.is_signed),
      .rdata_i  (mem_rdata),
      .wdata_i  (sdata_q),
      .load_o   (load_ext),
      .merge_o  (merged)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      sdata_d = sdata_q;
      err_d   = err_q;
      load_d  = load_q;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               req_d   = '{is_store: is_store, size: size_in,
                           is_signed: ~funct3[2], offset: addr[2:0]};
               sdata_d = store_data;
               load_d  = '0;
               err_d   = bad_in;
               if (bad_in) begin
                  state_d = ST_FINISH;
               end else begin
                  maddr_d = {addr[DATA_W-1:3], 3'b000};
                  if (is_store && (size_in == SZ_D)) begin
                     wdata_d = store_data;
                     wr_d    = 1'b1;
                     state_d = ST_WRITE;
                  end else begin
                     cnt_d   = CNT_INIT;
                     state_d = ST_READ;
                  end
               end
            end
         end
         ST_READ: begin
            if (cnt_q == 2'd0) begin
               if (req_q.is_store) begin
                  wdata_d = merged;
                  wr_d    = 1'b1;
                  state_d = ST_WRITE;
               end else begin
                  load_d  = load_ext;
                  state_d = ST_FINISH;
               end
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_WRITE:  state_d = ST_FINISH;
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         sdata_q <= '0;
         err_q   <= 1'b0;
         load_q  <= '0;
         maddr_q <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         sdata_q <= sdata_d;
         err_q   <= err_d;
         load_q  <= load_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
      end
   end

   assign busy      = (state_q == ST_READ) || (state_q == ST_WRITE);
   assign done      = (state_q == ST_FINISH);
   assign err       = done & err_q;
   assign load_data = load_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign mem_wr    = wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: two instances (read latency 1 and 3), each
// backed by a memory model that returns garbage until mem_addr has been stable long enough.
module tb_load_store_unit;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start_s [2];
   logic        is_store_s [2];
   logic [2:0]  f3_s [2];
   logic [63:0] addr_s [2];
   logic [63:0] sd_s [2];
   logic        busy_s [2];
   logic        done_s [2];
   logic        err_s [2];
   logic [63:0] ld_s [2];
   logic [63:0] maddr_s [2];
   logic [63:0] mwdata_s [2];
   logic        mwr_s [2];
   logic [63:0] mrdata_s [2];

   load_store_unit #(.MEM_RD_LAT(LAT0), .DATA_W(64)) dut_l1 (
      .clk(clk), .rst(rst), .start(start_s[0]), .is_store(is_store_s[0]),
      .funct3(f3_s[0]), .addr(addr_s[0]), .store_data(sd_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .load_data(ld_s[0]),
      .mem_addr(maddr_s[0]), .mem_wdata(mwdata_s[0]), .mem_wr(mwr_s[0]),
      .mem_rdata(mrdata_s[0]));

   load_store_unit #(.MEM_RD_LAT(LAT1), .DATA_W(64)) dut_l3 (
      .clk(clk), .rst(rst), .start(start_s[1]), .is_store(is_store_s[1]),
      .funct3(f3_s[1]), .addr(addr_s[1]), .store_data(sd_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .load_data(ld_s[1]),
      .mem_addr(maddr_s[1]), .mem_wdata(mwdata_s[1]), .mem_wr(mwr_s[1]),
      .mem_rdata(mrdata_s[1]));

   // Memory model: 16 doublewords per instance at 0x100.., data valid only once
   // mem_addr has been held for the instance's read latency.
   logic [63:0] mem [2][16];
   logic [63:0] held_addr [2];
   int          age [2];
   int          held [2];
   logic        mem_load;

   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (mem_load) begin
            mem[g][0] <= 64'h8877_6655_4433_2211;
            mem[g][1] <= 64'h0123_4567_89AB_CDEF;
         end else if (mwr_s[g]) begin
            mem[g][maddr_s[g][6:3]] <= mwdata_s[g];
         end
         age[g]       <= (maddr_s[g] == held_addr[g]) ? age[g] + 1 : 1;
         held_addr[g] <= maddr_s[g];
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++) begin
         held[g]     = (maddr_s[g] == held_addr[g]) ? age[g] + 1 : 1;
         mrdata_s[g] = 64'hDEAD_BEEF_DEAD_BEEF;
         if (held[g] >= ((g == 0) ? LAT0 : LAT1)) mrdata_s[g] = mem[g][maddr_s[g][6:3]];
      end
   end

   typedef struct {
      string       nm;
      int          sel;
      logic        st;
      logic [2:0]  f3;
      logic [63:0] a;
      logic [63:0] sd;
      int          done_cyc;
      logic        err;
      logic [63:0] ld;
      int          wr_cyc;
      logic [63:0] wdata;
   } tv_t;

   typedef struct {
      int          done_cyc;
      logic        err;
      logic [63:0] ld;
      int          wr_cnt;
      int          wr_cyc;
      logic [63:0] wdata;
      logic        busy1;
      logic        busy_done;
   } obs_t;

   tv_t exp_q[$];
   int  passed = 0;
   int  total  = 0;

   function automatic tv_t mk(string nm, int sel, logic st, logic [2:0] f3, logic [63:0] a,
                              logic [63:0] sd, int dc, logic e, logic [63:0] ld, int wc,
                              logic [63:0] wd);
      tv_t v;
      v.nm = nm; v.sel = sel; v.st = st; v.f3 = f3; v.a = a; v.sd = sd;
      v.done_cyc = dc; v.err = e; v.ld = ld; v.wr_cyc = wc; v.wdata = wd;
      return v;
   endfunction

   task automatic issue(input tv_t v, output int s);
      @(negedge clk);
      exp_q.push_back(v);
      start_s[v.sel]    = 1'b1;
      is_store_s[v.sel] = v.st;
      f3_s[v.sel]       = v.f3;
      addr_s[v.sel]     = v.a;
      sd_s[v.sel]       = v.sd;
      s = cyc;
   endtask

   task automatic collect(input int sel, input int s, output obs_t o);
      o.done_cyc = -1; o.err = 1'b0; o.ld = '0; o.wr_cnt = 0; o.wr_cyc = -1;
      o.wdata = '0; o.busy1 = 1'b0; o.busy_done = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         start_s[sel] = 1'b0;
         if (cyc - s == 1) o.busy1 = busy_s[sel];
         if (mwr_s[sel]) begin
            o.wr_cnt++;
            o.wr_cyc = cyc - s;
            o.wdata  = mwdata_s[sel];
         end
         if (done_s[sel]) begin
            o.done_cyc  = cyc - s;
            o.err       = err_s[sel];
            o.ld        = ld_s[sel];
            o.busy_done = busy_s[sel];
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      start_s[0] = 1'b1; is_store_s[0] = 1'b0; f3_s[0] = 3'b011; addr_s[0] = 64'h100;
      @(negedge clk);
      rst = 1'b0; start_s[0] = 1'b0;
      for (int g = 0; g < 2; g++) begin
         total++;
         if ({busy_s[g], done_s[g], err_s[g], mwr_s[g]} !== 4'b0)
            $display("FAIL reset_ctrl[%0d] got %b want 0000", g,
                     {busy_s[g], done_s[g], err_s[g], mwr_s[g]});
         else passed++;
         total++;
         if ({ld_s[g], maddr_s[g], mwdata_s[g]} !== 192'b0)
            $display("FAIL reset_data[%0d] got %h/%h/%h want 0", g, ld_s[g], maddr_s[g], mwdata_s[g]);
         else passed++;
      end
      @(negedge clk);
      total++;
      if (busy_s[0] !== 1'b0) $display("FAIL start_with_rst busy got %b want 0", busy_s[0]);
      else passed++;
   endtask

   task automatic test_loads();
      tv_t v[7];
      tv_t e;
      obs_t o;
      int s;
      v[0] = mk("lb_107",  0, 0, 3'b000, 64'h107, 0, 2, 0, 64'hFFFF_FFFF_FFFF_FF88, -1, 0);
      v[1] = mk("lbu_107", 0, 0, 3'b100, 64'h107, 0, 2, 0, 64'h0000_0000_0000_0088, -1, 0);
      v[2] = mk("lw_104",  0, 0, 3'b010, 64'h104, 0, 2, 0, 64'hFFFF_FFFF_8877_6655, -1, 0);
      v[3] = mk("lwu_104", 0, 0, 3'b110, 64'h104, 0, 2, 0, 64'h0000_0000_8877_6655, -1, 0);
      v[4] = mk("ld_100",  0, 0, 3'b011, 64'h100, 0, 2, 0, 64'h8877_6655_4433_2211, -1, 0);
      v[5] = mk("lh_106",  0, 0, 3'b001, 64'h106, 0, 2, 0, 64'hFFFF_FFFF_FFFF_8877, -1, 0);
      v[6] = mk("lhu_102", 0, 0, 3'b101, 64'h102, 0, 2, 0, 64'h0000_0000_0000_4433, -1, 0);
      for (int i = 0; i < 7; i++) begin
         issue(v[i], s);
         collect(v[i].sel, s, o);
         e = exp_q.pop_front();
         total++;
         if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
         else passed++;
         total++;
         if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
         else passed++;
         total++;
         if ({o.err, o.busy1, o.busy_done} !== 3'b010)
            $display("FAIL %s err/busy1/busy_at_done got %b want 010", e.nm, {o.err, o.busy1, o.busy_done});
         else passed++;
         total++;
         if (o.wr_cnt !== 0) $display("FAIL %s mem_wr_count got %0d want 0", e.nm, o.wr_cnt);
         else passed++;
      end
   endtask

   task automatic test_stores();
      tv_t v[7];
      tv_t e;
      obs_t o;
      int s;
      v[0] = mk("sh_102_l1", 0, 1, 3'b001, 64'h102, 64'hFFFF_0000_1234_ABCD, 3, 0, 0, 2, 64'h8877_6655_ABCD_2211);
      v[1] = mk("sb_105_l1", 0, 1, 3'b000, 64'h105, 64'h0000_0000_0000_115A, 3, 0, 0, 2, 64'h8877_5A55_ABCD_2211);
      v[2] = mk("sw_100_l1", 0, 1, 3'b010, 64'h100, 64'hDEAD_BEEF_0102_0304, 3, 0, 0, 2, 64'h8877_5A55_0102_0304);
      v[3] = mk("sd_108_l3", 1, 1, 3'b011, 64'h108, 64'hCAFE_F00D_1234_5678, 2, 0, 0, 1, 64'hCAFE_F00D_1234_5678);
      v[4] = mk("sh_102_l3", 1, 1, 3'b001, 64'h102, 64'h0000_0000_0000_ABCD, 5, 0, 0, 4, 64'h8877_6655_ABCD_2211);
      v[5] = mk("sd_108_l1", 0, 1, 3'b011, 64'h108, 64'h1122_3344_5566_7788, 2, 0, 0, 1, 64'h1122_3344_5566_7788);
      v[6] = mk("ld_100_l1", 0, 0, 3'b011, 64'h100, 0, 2, 0, 64'h8877_5A55_0102_0304, -1, 0);
      for (int i = 0; i < 7; i++) begin
         issue(v[i], s);
         collect(v[i].sel, s, o);
         e = exp_q.pop_front();
         total++;
         if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
         else passed++;
         total++;
         if (o.wr_cnt !== ((e.wr_cyc < 0) ? 0 : 1)) $display("FAIL %s mem_wr_count got %0d want %0d", e.nm, o.wr_cnt, (e.wr_cyc < 0) ? 0 : 1);
         else passed++;
         total++;
         if (o.wr_cyc !== e.wr_cyc) $display("FAIL %s mem_wr_cycle got %0d want %0d", e.nm, o.wr_cyc, e.wr_cyc);
         else passed++;
         total++;
         if (o.wdata !== e.wdata) $display("FAIL %s mem_wdata got %h want %h", e.nm, o.wdata, e.wdata);
         else passed++;
         if (!e.st) begin
            total++;
            if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
            else passed++;
         end
      end
   endtask

   task automatic test_errors();
      tv_t v[6];
      tv_t e;
      obs_t o;
      int s;
      v[0] = mk("ld_108_prime", 0, 0, 3'b011, 64'h108, 0, 2, 0, 64'h1122_3344_5566_7788, -1, 0);
      v[1] = mk("lw_102_mis",   0, 0, 3'b010, 64'h102, 0, 1, 1, 0, -1, 0);
      v[2] = mk("sh_101_mis",   0, 1, 3'b001, 64'h101, 64'h55AA, 1, 1, 0, -1, 0);
      v[3] = mk("st_f3_100",    0, 1, 3'b100, 64'h100, 64'h77, 1, 1, 0, -1, 0);
      v[4] = mk("ld_f3_111",    0, 0, 3'b111, 64'h100, 0, 1, 1, 0, -1, 0);
      v[5] = mk("ld_104_mis",   1, 0, 3'b011, 64'h104, 0, 1, 1, 0, -1, 0);
      for (int i = 0; i < 6; i++) begin
         issue(v[i], s);
         collect(v[i].sel, s, o);
         e = exp_q.pop_front();
         total++;
         if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
         else passed++;
         total++;
         if (o.err !== e.err) $display("FAIL %s err got %b want %b", e.nm, o.err, e.err);
         else passed++;
         total++;
         if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
         else passed++;
         total++;
         if (o.wr_cnt !== 0) $display("FAIL %s mem_wr_count got %0d want 0", e.nm, o.wr_cnt);
         else passed++;
      end
   endtask

   task automatic test_reset_abort();
      tv_t e;
      obs_t o;
      int s;
      int wr_seen;
      int done_seen;
      issue(mk("sb_abort", 1, 1, 3'b000, 64'h103, 64'h77, -1, 0, 0, -1, 0), s);
      @(negedge clk);
      start_s[1] = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      e = exp_q.pop_front();
      total++;
      if ({busy_s[1], done_s[1], err_s[1], mwr_s[1]} !== 4'b0)
         $display("FAIL %s ctrl_after_rst got %b want 0000", e.nm, {busy_s[1], done_s[1], err_s[1], mwr_s[1]});
      else passed++;
      total++;
      if ({ld_s[1], maddr_s[1], mwdata_s[1]} !== 192'b0)
         $display("FAIL %s data_after_rst got %h/%h/%h want 0", e.nm, ld_s[1], maddr_s[1], mwdata_s[1]);
      else passed++;
      rst = 1'b0;
      wr_seen = 0;
      done_seen = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (mwr_s[1]) wr_seen++;
         if (done_s[1]) done_seen++;
      end
      total++;
      if (wr_seen !== 0 || done_seen !== 0)
         $display("FAIL %s after_abort wr=%0d done=%0d want 0/0", e.nm, wr_seen, done_seen);
      else passed++;
      issue(mk("ld_after_abort", 1, 0, 3'b011, 64'h100, 0, 4, 0, 64'h8877_6655_ABCD_2211, -1, 0), s);
      collect(1, s, o);
      e = exp_q.pop_front();
      total++;
      if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
      else passed++;
      total++;
      if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
      else passed++;
   endtask

   task automatic test_busy_ignore();
      tv_t e;
      obs_t o;
      int s;
      issue(mk("lb_busy", 1, 0, 3'b000, 64'h107, 0, 4, 0, 64'hFFFF_FFFF_FFFF_FF88, -1, 0), s);
      @(negedge clk);
      start_s[1] = 1'b1; is_store_s[1] = 1'b1; f3_s[1] = 3'b011;
      addr_s[1] = 64'h100; sd_s[1] = 64'h0;
      collect(1, s, o);
      e = exp_q.pop_front();
      total++;
      if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
      else passed++;
      total++;
      if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
      else passed++;
      total++;
      if (o.wr_cnt !== 0) $display("FAIL %s mem_wr_count got %0d want 0", e.nm, o.wr_cnt);
      else passed++;
      // start held during FINISH must not launch a new access
      start_s[1] = 1'b1; is_store_s[1] = 1'b0; f3_s[1] = 3'b000; addr_s[1] = 64'h100;
      @(negedge clk);
      start_s[1] = 1'b0;
      total++;
      if (busy_s[1] !== 1'b0) $display("FAIL start_in_finish busy got %b want 0", busy_s[1]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      tv_t v[2];
      tv_t e;
      obs_t o;
      int s;
      v[0] = mk("b2b_lbu_107", 0, 0, 3'b100, 64'h107, 0, 2, 0, 64'h0000_0000_0000_0088, -1, 0);
      v[1] = mk("b2b_ld_108",  0, 0, 3'b011, 64'h108, 0, 2, 0, 64'h1122_3344_5566_7788, -1, 0);
      for (int i = 0; i < 2; i++) begin
         issue(v[i], s);
         collect(v[i].sel, s, o);
         e = exp_q.pop_front();
         total++;
         if (o.done_cyc !== e.done_cyc) $display("FAIL %s done_cycle got %0d want %0d", e.nm, o.done_cyc, e.done_cyc);
         else passed++;
         total++;
         if (o.ld !== e.ld) $display("FAIL %s load_data got %h want %h", e.nm, o.ld, e.ld);
         else passed++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      mem_load = 1'b1;
      for (int g = 0; g < 2; g++) begin
         start_s[g] = 1'b0; is_store_s[g] = 1'b0; f3_s[g] = 3'b000;
         addr_s[g] = '0; sd_s[g] = '0;
      end
      repeat (2) @(negedge clk);
      mem_load = 1'b0;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_reset_abort();
      test_busy_ignore();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
